// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM port bundle between one master and the RAM arbiter.
// master: address/read/write/byteenable/writedata; slave: waitrequest/readdata/readdatavalid.
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write,
    output byteenable, writedata,
    input  waitrequest, readdata,
    input  readdatavalid
  );

  modport slave (
    input  address, read, write,
    input  byteenable, writedata,
    output waitrequest, readdata,
    output readdatavalid
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter for the single-port on-chip RAM (M0 = instr reads, M1 = data rd/wr).
// Ports: clk, reset_n (sync, low), m0/m1 slave bundles, mem_* RAM side. ARB_ROUND_ROBIN_EN: alternate.
module onchip_mem_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  onchip_mem_arbiter_if.slave m0,
  onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);
  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } gnt_e;

  gnt_e       last_q, last_d;
  gnt_e       owner_q, owner_d;
  logic [3:0] hold_q, hold_d;
  logic       pend_q, pend_d;

  logic req0, req1, contested, forced;
  logic pick1, gnt0, gnt1;
  logic vld0, vld1;

  always_comb begin
    req0      = reset_n & m0.read;
    req1      = reset_n & (m1.read | m1.write);
    contested = req0 & req1;
    forced    = (hold_q >= HOLD_LIM);
`ifdef ARB_ROUND_ROBIN_EN
    pick1     = (last_q == GNT_M0);
`else
    // M1 by default; M0 only once M1 has used up its hold budget
    pick1     = forced ? (last_q == GNT_M0) : 1'b1;
`endif
    gnt1      = req1 & (~req0 | pick1);
    gnt0      = req0 & ~gnt1;
  end

  always_comb begin
    last_d  = last_q;
    hold_d  = '0;
    pend_d  = gnt0 | (gnt1 & m1.read & ~m1.write);
    owner_d = gnt1 ? GNT_M1 : GNT_M0;
    if (gnt0) last_d = GNT_M0;
    else if (gnt1) last_d = GNT_M1;
    // a forced hand-over leaves the count at zero
    if (contested && !forced) begin
      if (last_d == last_q) hold_d = hold_q + 4'd1;
      else hold_d = 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q  <= GNT_M1;
      hold_q  <= '0;
      pend_q  <= 1'b0;
      owner_q <= GNT_M0;
    end else begin
      last_q  <= last_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      owner_q <= owner_d;
    end
  end

  assign mem_clken      = reset_n;
  assign mem_chipselect = gnt0 | gnt1;
  assign mem_write      = gnt1 & m1.write;
  assign mem_address    = gnt1 ? m1.address
                                : m0.address;
  assign mem_byteenable = gnt1 ? m1.byteenable
                                : '1;
  assign mem_writedata  = m1.writedata;

  assign m0.waitrequest = ~reset_n | (req0 & ~gnt0);
  assign m1.waitrequest = ~reset_n | (req1 & ~gnt1);

  assign vld0 = reset_n & pend_q & (owner_q == GNT_M0);
  assign vld1 = reset_n & pend_q & (owner_q == GNT_M1);

  assign m0.readdatavalid = vld0;
  assign m1.readdatavalid = vld1;
  assign m0.readdata      = vld0 ? mem_readdata : '0;
  assign m1.readdata      = vld1 ? mem_readdata : '0;

  // M0 is read-only; its write-side lanes are never looked at
  logic unused_m0;
  assign unused_m0 = ^{m0.byteenable, m0.writedata};

  a_m1_rw: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(m1.read && m1.write));

  a_m0_wr: assert property (
    @(posedge clk) disable iff (!reset_n)
    !m0.write);
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: RAM model, read scoreboard.
// Per-scenario tasks; expected reads pushed at grant, popped when due.
module tb_onchip_mem_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;

  logic clk;
  logic reset_n;
  logic [AW-1:0] mem_address;
  logic mem_chipselect, mem_write, mem_clken;
  logic [3:0] mem_byteenable;
  logic [DW-1:0] mem_writedata, mem_readdata;

  onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

  onchip_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .m0(m0_if),
    .m1(m1_if),
    .mem_address(mem_address),
    .mem_chipselect(mem_chipselect),
    .mem_write(mem_write),
    .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata),
    .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered address, unregistered q
  logic [31:0] ram [0:16383];
  logic [31:0] shadow [0:16383];
  logic [AW-1:0] raddr_q;
  logic ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0] ld_data;

  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (mem_clken && mem_chipselect) begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b])
            ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      raddr_q <= mem_address;
    end
  end
  assign mem_readdata = ram[raddr_q];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  logic mon_en;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic owner;
    logic [31:0] data;
    int due;
  } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin : mon
    logic e0, e1;
    logic [31:0] ed, got, oth;
    if (mon_en) begin
      e0 = 1'b0; e1 = 1'b0; ed = '0;
      if (!reset_n) sbq.delete();
      else if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e0 = ~sbq[0].owner;
        e1 = sbq[0].owner;
        ed = sbq[0].data;
        void'(sbq.pop_front());
      end
      n_tests++;
      if (m0_if.readdatavalid !== e0 || m1_if.readdatavalid !== e1) begin
        n_fail++;
        $display("FAIL rdvalid cyc %0d: got m0=%b m1=%b want m0=%b m1=%b",
          cyc, m0_if.readdatavalid, m1_if.readdatavalid, e0, e1);
      end
      if (e0 || e1) begin
        got = e0 ? m0_if.readdata : m1_if.readdata;
        oth = e0 ? m1_if.readdata : m0_if.readdata;
        n_tests++;
        if (got !== ed || oth !== 32'h0) begin
          n_fail++;
          $display("FAIL rddata cyc %0d: got %h other %h want %h other 0",
            cyc, got, oth, ed);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    m0_if.read = 0; m0_if.write = 0;
    m0_if.byteenable = '0; m0_if.writedata = '0;
    m1_if.read = 0; m1_if.write = 0;
    m1_if.byteenable = 4'hF; m1_if.writedata = '0;
  endtask

  task automatic push(input logic own, input logic [31:0] d);
    sbq.push_back('{owner: own, data: d, due: cyc + 1});
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    ld_en = 1; ld_addr = a; ld_data = d;
    shadow[a] = d;
    tick();
    ld_en = 0;
  endtask

  task automatic do_reset;
    idle_in();
    reset_n = 0;
    tick();
    n_tests++;
    if (mem_clken !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clken: got %b want 0", mem_clken);
    end
    tick();
    reset_n = 1;
  endtask

  task automatic test_reset;
    idle_in();
    m0_if.read = 1; m1_if.read = 1;
    tick();
    n_tests++;
    if (m0_if.waitrequest !== 1 || m1_if.waitrequest !== 1) begin
      n_fail++;
      $display("FAIL reset_wait: got %b%b want 11",
        m0_if.waitrequest, m1_if.waitrequest);
    end
    n_tests++;
    if ({mem_chipselect, mem_write, mem_clken} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mem: got cs/wr/clken %b%b%b want 000",
        mem_chipselect, mem_write, mem_clken);
    end
    n_tests++;
    if (m0_if.readdatavalid !== 0 || m1_if.readdatavalid !== 0 ||
        m0_if.readdata !== 0 || m1_if.readdata !== 0) begin
      n_fail++;
      $display("FAIL reset_rd: got vld %b%b data %h %h want 0",
        m0_if.readdatavalid, m1_if.readdatavalid,
        m0_if.readdata, m1_if.readdata);
    end
    mon_en = 1;
    preload(14'h010, 32'hDEADBEEF);
    preload(14'h200, 32'hAABBCCDD);
    for (int i = 0; i < 32; i++) begin
      preload(14'h100 + 14'(i), $urandom);
      preload(14'h300 + 14'(i), $urandom);
    end
    idle_in();
    reset_n = 1;
    tick();
  endtask

  task automatic test_single_read;
    m0_if.address = 14'h010; m0_if.read = 1;
    #1;
    n_tests++;
    if (m0_if.waitrequest !== 0) begin
      n_fail++;
      $display("FAIL m0_read_wait: got %b want 0", m0_if.waitrequest);
    end
    n_tests++;
    if (mem_chipselect !== 1 || mem_address !== 14'h010 ||
        mem_byteenable !== 4'hF || mem_write !== 0) begin
      n_fail++;
      $display("FAIL m0_read_bus: got cs=%b a=%h be=%h wr=%b want 1 010 f 0",
        mem_chipselect, mem_address, mem_byteenable, mem_write);
    end
    push(1'b0, 32'hDEADBEEF);
    tick();
    idle_in();
    tick();
  endtask

  task automatic test_write_read;
    m1_if.address = 14'h200; m1_if.write = 1;
    m1_if.writedata = 32'h12345678; m1_if.byteenable = 4'b0011;
    #1;
    n_tests++;
    if (m1_if.waitrequest !== 0 || mem_write !== 1 ||
        mem_byteenable !== 4'b0011 || mem_writedata !== 32'h12345678 ||
        mem_address !== 14'h200) begin
      n_fail++;
      $display("FAIL m1_write: got w=%b wr=%b be=%b wd=%h a=%h want 0 1 0011 12345678 200",
        m1_if.waitrequest, mem_write, mem_byteenable,
        mem_writedata, mem_address);
    end
    tick();
    m1_if.write = 0; m1_if.read = 1; m1_if.byteenable = 4'hF;
    #1;
    n_tests++;
    if (m1_if.waitrequest !== 0 || mem_write !== 0) begin
      n_fail++;
      $display("FAIL m1_read: got wait=%b wr=%b want 0 0",
        m1_if.waitrequest, mem_write);
    end
    push(1'b1, 32'hAABB5678);
    tick();
    idle_in();
    tick();
  endtask

  task automatic test_contention;
    logic [AW-1:0] a0, a1;
    logic e1;
    do_reset();
    a0 = 14'h100; a1 = 14'h300;
    for (int i = 0; i < 20; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      e1 = (i % 2 == 1);
`else
      e1 = (i % 5 != 4);
`endif
      m0_if.read = 1; m0_if.address = a0;
      m1_if.read = 1; m1_if.address = a1;
      #1;
      n_tests++;
      if (m0_if.waitrequest !== e1 || m1_if.waitrequest !== ~e1 ||
          mem_address !== (e1 ? a1 : a0)) begin
        n_fail++;
        $display("FAIL contend[%0d]: got wait=%b%b a=%h want %b%b a=%h",
          i, m0_if.waitrequest, m1_if.waitrequest, mem_address,
          e1, ~e1, e1 ? a1 : a0);
      end
      push(e1, shadow[e1 ? a1 : a0]);
      if (e1) a1 = a1 + 1;
      else a0 = a0 + 1;
      tick();
    end
    idle_in();
    tick();
  endtask

  task automatic test_hold_clear;
    bit r0v [9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
`ifdef ARB_ROUND_ROBIN_EN
    bit e1v [9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
`else
    bit e1v [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
`endif
    logic [AW-1:0] a0, a1;
    logic r0, e1;
    do_reset();
    a0 = 14'h110; a1 = 14'h314;
    for (int i = 0; i < 9; i++) begin
      r0 = r0v[i]; e1 = e1v[i];
      m0_if.read = r0; m0_if.address = a0;
      m1_if.read = 1; m1_if.address = a1;
      #1;
      n_tests++;
      if (m0_if.waitrequest !== (r0 & e1) ||
          m1_if.waitrequest !== ~e1) begin
        n_fail++;
        $display("FAIL hold[%0d]: got wait=%b%b want %b%b",
          i, m0_if.waitrequest, m1_if.waitrequest, r0 & e1, ~e1);
      end
      push(e1, shadow[e1 ? a1 : a0]);
      if (e1) a1 = a1 + 1;
      else a0 = a0 + 1;
      tick();
    end
    idle_in();
    tick();
  endtask

  task automatic test_reset_mid_read;
    logic e1;
    m0_if.read = 1; m0_if.address = 14'h105;
    #1;
    n_tests++;
    if (m0_if.waitrequest !== 0) begin
      n_fail++;
      $display("FAIL midrst_acc: got %b want 0", m0_if.waitrequest);
    end
    push(1'b0, shadow[14'h105]);
    tick();
    reset_n = 0;
    m0_if.address = 14'h106;
    m1_if.read = 1; m1_if.address = 14'h301;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if (mem_clken !== 0 || mem_chipselect !== 0 ||
          m0_if.waitrequest !== 1 || m1_if.waitrequest !== 1) begin
        n_fail++;
        $display("FAIL midrst_hold[%0d]: got clken=%b cs=%b wait=%b%b want 0 0 11",
          i, mem_clken, mem_chipselect,
          m0_if.waitrequest, m1_if.waitrequest);
      end
      tick();
    end
    reset_n = 1;
`ifdef ARB_ROUND_ROBIN_EN
    e1 = 1'b0;
`else
    e1 = 1'b1;
`endif
    #1;
    n_tests++;
    if (m0_if.waitrequest !== e1 || m1_if.waitrequest !== ~e1 ||
        mem_clken !== 1) begin
      n_fail++;
      $display("FAIL midrst_first: got wait=%b%b clken=%b want %b%b 1",
        m0_if.waitrequest, m1_if.waitrequest, mem_clken, e1, ~e1);
    end
    push(e1, shadow[e1 ? 14'h301 : 14'h106]);
    tick();
    idle_in();
    tick();
  endtask

  task automatic test_idle;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_tests++;
      if (mem_chipselect !== 0 || mem_write !== 0 ||
          m0_if.waitrequest !== 0 || m1_if.waitrequest !== 0) begin
        n_fail++;
        $display("FAIL idle[%0d]: got cs=%b wr=%b wait=%b%b want 0 0 00",
          i, mem_chipselect, mem_write,
          m0_if.waitrequest, m1_if.waitrequest);
      end
      tick();
    end
    m0_if.read = 1; m0_if.address = 14'h107;
    m1_if.read = 1; m1_if.address = 14'h302;
    #1;
    n_tests++;
    if (m0_if.waitrequest !== 1 || m1_if.waitrequest !== 0) begin
      n_fail++;
      $display("FAIL idle_after: got wait=%b%b want 10",
        m0_if.waitrequest, m1_if.waitrequest);
    end
    push(1'b1, shadow[14'h302]);
    tick();
    idle_in();
    tick();
  endtask

  initial begin
    mon_en = 0;
    ld_en = 0; ld_addr = '0; ld_data = '0;
    reset_n = 0;
    m0_if.address = '0;
    m1_if.address = '0;
    idle_in();
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_hold_clear();
    test_reset_mid_read();
    test_idle();
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d left want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
